// File: rtl/video_timing_driver.sv
// Raster timing generator for the DVI path: hsync/vsync/de plus a coordinate
// request port whose early issue hides the drawing logic's fixed latency.
module video_timing_driver #(
  parameter int unsigned H_SYNC      = 40,
  parameter int unsigned H_BACK      = 220,
  parameter int unsigned H_DISP      = 1280,
  parameter int unsigned H_FRONT     = 110,
  parameter int unsigned V_SYNC      = 5,
  parameter int unsigned V_BACK      = 20,
  parameter int unsigned V_DISP      = 720,
  parameter int unsigned V_FRONT     = 5,
  parameter int unsigned SYNC_POL    = 1,
  parameter int unsigned PIX_LATENCY = 2
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        pattern_en,
  output logic        pixel_req,
  output logic [11:0] pixel_xpos,
  output logic [11:0] pixel_ypos,
  input  logic [23:0] pixel_data,
  output logic        video_hsync,
  output logic        video_vsync,
  output logic        video_de,
  output logic [23:0] video_rgb,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
  localparam logic [11:0] HA_W      = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] VA_W      = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] REQ_START = 12'(H_SYNC + H_BACK - PIX_LATENCY);
  localparam logic [11:0] H_DISP_W  = 12'(H_DISP);
  localparam logic [11:0] V_DISP_W  = 12'(V_DISP);
  localparam logic [11:0] H_SYNC_W  = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_W  = 12'(V_SYNC);
  localparam logic [11:0] BAR_W     = 12'(H_DISP / 8);
  localparam logic        SYNC_ON   = (SYNC_POL != 0);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic [11:0] h_rel, v_rel, req_rel;
  logic        h_act, v_act, de_raw, req;
  logic [23:0] bar_rgb;

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [23:0] rgb_q, rgb_d;
  logic        fs_q, fs_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 12'd1;
    end
  end

  // Window tests use wrapped offsets: a count below the window start wraps
  // far above the window length, so one unsigned compare covers both ends.
  always_comb begin
    h_rel   = h_cnt_q - HA_W;
    v_rel   = v_cnt_q - VA_W;
    req_rel = h_cnt_q - REQ_START;
    h_act   = (h_rel < H_DISP_W);
    v_act   = (v_rel < V_DISP_W);
    de_raw  = h_act && v_act;
    req     = v_act && (req_rel < H_DISP_W);
  end

  always_comb begin
    bar_rgb = 24'h000000;
    case (h_rel / BAR_W)
      12'd0:   bar_rgb = 24'hFFFFFF;
      12'd1:   bar_rgb = 24'hFFFF00;
      12'd2:   bar_rgb = 24'h00FFFF;
      12'd3:   bar_rgb = 24'h00FF00;
      12'd4:   bar_rgb = 24'hFF00FF;
      12'd5:   bar_rgb = 24'hFF0000;
      12'd6:   bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    hsync_d = (h_cnt_q < H_SYNC_W) ? SYNC_ON : ~SYNC_ON;
    vsync_d = (v_cnt_q < V_SYNC_W) ? SYNC_ON : ~SYNC_ON;
    de_d    = de_raw;
    rgb_d   = de_raw ? (pattern_en ? bar_rgb : pixel_data) : '0;
    fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= ~SYNC_ON;
      vsync_q <= ~SYNC_ON;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
    end
  end

  assign pixel_req   = req;
  assign pixel_xpos  = req ? req_rel : '0;
  assign pixel_ypos  = req ? v_rel : '0;
  assign video_hsync = hsync_q;
  assign video_vsync = vsync_q;
  assign video_de    = de_q;
  assign video_rgb   = rgb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_driver.sv
// Scoreboard bench for video_timing_driver on a reduced raster; four instances
// cover latency 2/1/HA, pattern mode, and an active-low mid-frame reset.
module tb_video_timing_driver;

  localparam int HS = 4,  HB = 6,  HD = 16, HF = 3;
  localparam int VS = 2,  VB = 3,  VD = 6,  VF = 2;
  localparam int HA = HS + HB;
  localparam int VA = VS + VB;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FR = HT * VT;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic rst_n = 1'b0, rst3_n = 1'b0, pat_en = 1'b0;

  logic        req0, req1, req2, req3;
  logic [11:0] x0, x1, x2, x3, y0, y1, y2, y3;
  logic [23:0] d0, d1, d2, d3, rgb0, rgb1, rgb2, rgb3;
  logic        hs0, hs1, hs2, hs3, vs0, vs1, vs2, vs3;
  logic        de0, de1, de2, de3, fs0, fs1, fs2, fs3;

  video_timing_driver #(.H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .SYNC_POL(1), .PIX_LATENCY(2)) u0 (
    .pclk(pclk), .reset_n(rst_n), .pattern_en(pat_en), .pixel_req(req0), .pixel_xpos(x0),
    .pixel_ypos(y0), .pixel_data(d0), .video_hsync(hs0), .video_vsync(vs0), .video_de(de0),
    .video_rgb(rgb0), .frame_start(fs0));

  video_timing_driver #(.H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .SYNC_POL(1), .PIX_LATENCY(1)) u1 (
    .pclk(pclk), .reset_n(rst_n), .pattern_en(1'b0), .pixel_req(req1), .pixel_xpos(x1),
    .pixel_ypos(y1), .pixel_data(d1), .video_hsync(hs1), .video_vsync(vs1), .video_de(de1),
    .video_rgb(rgb1), .frame_start(fs1));

  video_timing_driver #(.H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .SYNC_POL(1), .PIX_LATENCY(HA)) u2 (
    .pclk(pclk), .reset_n(rst_n), .pattern_en(1'b0), .pixel_req(req2), .pixel_xpos(x2),
    .pixel_ypos(y2), .pixel_data(d2), .video_hsync(hs2), .video_vsync(vs2), .video_de(de2),
    .video_rgb(rgb2), .frame_start(fs2));

  video_timing_driver #(.H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .SYNC_POL(0), .PIX_LATENCY(2)) u3 (
    .pclk(pclk), .reset_n(rst3_n), .pattern_en(1'b0), .pixel_req(req3), .pixel_xpos(x3),
    .pixel_ypos(y3), .pixel_data(d3), .video_hsync(hs3), .video_vsync(vs3), .video_de(de3),
    .video_rgb(rgb3), .frame_start(fs3));

  // Drawing-logic model: returns {x,y} exactly LATENCY cycles after the request.
  logic [23:0] pa[2], pb[1], pc[HA], pd[2];
  always @(posedge pclk) begin
    pa[0] <= {x0, y0};
    pa[1] <= pa[0];
    pb[0] <= {x1, y1};
    pc[0] <= {x2, y2};
    for (int j = 1; j < HA; j++) pc[j] <= pc[j-1];
    pd[0] <= {x3, y3};
    pd[1] <= pd[0];
  end
  assign d0 = pa[1];
  assign d1 = pb[0];
  assign d2 = pc[HA-1];
  assign d3 = pd[1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit act_hv(input int h, input int v);
    return (h >= HA) && (h < HA + HD) && (v >= VA) && (v < VA + VD);
  endfunction

  function automatic bit req_exp(input int h, input int v, input int lat);
    return (v >= VA) && (v < VA + VD) && (h >= HA - lat) && (h < HA + HD - lat);
  endfunction

  function automatic logic [23:0] xy(input int h, input int v);
    logic [11:0] xx, yy;
    xx = 12'(h - HA);
    yy = 12'(v - VA);
    return {xx, yy};
  endfunction

  function automatic logic [23:0] bar(input int x);
    case (x / (HD / 8))
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Reference raster: c* is the counter state, o* the state last registered.
  int ch0 = 0, cv0 = 0, oh0 = 0, ov0 = 0, ch1 = 0, cv1 = 0, oh1 = 0, ov1 = 0;
  bit ovld0 = 1'b0, ovld1 = 1'b0;
  logic [23:0] q0[$], q1[$], q2[$], q3[$];

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      ch0 <= 0; cv0 <= 0; oh0 <= 0; ov0 <= 0; ovld0 <= 1'b0;
      q0.delete(); q1.delete(); q2.delete();
    end else begin
      if (act_hv(ch0, cv0)) begin
        q0.push_back(pat_en ? bar(ch0 - HA) : xy(ch0, cv0));
        q1.push_back(xy(ch0, cv0));
        q2.push_back(xy(ch0, cv0));
      end
      oh0 <= ch0; ov0 <= cv0; ovld0 <= 1'b1;
      ch0 <= (ch0 == HT - 1) ? 0 : ch0 + 1;
      if (ch0 == HT - 1) cv0 <= (cv0 == VT - 1) ? 0 : cv0 + 1;
    end
  end

  always @(posedge pclk or negedge rst3_n) begin
    if (!rst3_n) begin
      ch1 <= 0; cv1 <= 0; oh1 <= 0; ov1 <= 0; ovld1 <= 1'b0;
      q3.delete();
    end else begin
      if (act_hv(ch1, cv1)) q3.push_back(xy(ch1, cv1));
      oh1 <= ch1; ov1 <= cv1; ovld1 <= 1'b1;
      ch1 <= (ch1 == HT - 1) ? 0 : ch1 + 1;
      if (ch1 == HT - 1) cv1 <= (cv1 == VT - 1) ? 0 : cv1 + 1;
    end
  end

  int  hsw0 = 0, hsp0 = 0, cyc0 = 0, dec0 = 0, vsc0 = 0, frames0 = 0;
  int  cyc3 = 0, dec3 = 0, vsc3 = 0, frames3 = 0;
  bit  hsr0_seen = 1'b0, seen0 = 1'b0, seen3 = 1'b0;
  logic hs0_prev = 1'b0, req2_prev = 1'b0;

  always @(negedge pclk) begin
    chk("hsync0", hs0, ovld0 && oh0 < HS);
    chk("vsync0", vs0, ovld0 && ov0 < VS);
    chk("de0", de0, ovld0 && act_hv(oh0, ov0));
    chk("frame_start0", fs0, ovld0 && oh0 == 0 && ov0 == 0);
    chk("de1", de1, ovld0 && act_hv(oh0, ov0));
    chk("de2", de2, ovld0 && act_hv(oh0, ov0));
    chk("req0", req0, req_exp(ch0, cv0, 2));
    chk("xpos0", x0, req_exp(ch0, cv0, 2) ? ch0 - (HA - 2) : 0);
    chk("ypos0", y0, req_exp(ch0, cv0, 2) ? cv0 - VA : 0);
    chk("req1", req1, req_exp(ch0, cv0, 1));
    chk("req2", req2, req_exp(ch0, cv0, HA));
    if (req2 && !req2_prev) chk("req2_rise_hcnt", ch0, 0);
    req2_prev = req2;

    if (de0) begin
      if (q0.size() == 0) chk("rgb0_expected_pending", q0.size(), 1);
      else chk("rgb0", rgb0, q0.pop_front());
    end else chk("rgb0_blank", rgb0, 0);
    if (de1) begin
      if (q1.size() == 0) chk("rgb1_expected_pending", q1.size(), 1);
      else chk("rgb1", rgb1, q1.pop_front());
    end else chk("rgb1_blank", rgb1, 0);
    if (de2) begin
      if (q2.size() == 0) chk("rgb2_expected_pending", q2.size(), 1);
      else chk("rgb2", rgb2, q2.pop_front());
    end else chk("rgb2_blank", rgb2, 0);

    chk("hsync3", hs3, !(ovld1 && oh1 < HS));
    chk("vsync3", vs3, !(ovld1 && ov1 < VS));
    chk("de3", de3, ovld1 && act_hv(oh1, ov1));
    chk("frame_start3", fs3, ovld1 && oh1 == 0 && ov1 == 0);
    if (de3) begin
      if (q3.size() == 0) chk("rgb3_expected_pending", q3.size(), 1);
      else chk("rgb3", rgb3, q3.pop_front());
    end else chk("rgb3_blank", rgb3, 0);

    // Raw-output measurements of pulse widths and frame contents.
    if (hs0) hsw0++;
    else if (hsw0 != 0) begin
      chk("hsync_width0", hsw0, HS);
      hsw0 = 0;
    end
    if (hs0 && !hs0_prev) begin
      if (hsr0_seen) chk("hsync_period0", hsp0, HT);
      hsp0 = 0;
      hsr0_seen = 1'b1;
    end
    hsp0++;
    hs0_prev = hs0;

    if (fs0) begin
      if (seen0) begin
        chk("frame_period0", cyc0, FR);
        chk("de_per_frame0", dec0, HD * VD);
        chk("vsync_per_frame0", vsc0, VS * HT);
        frames0++;
      end
      cyc0 = 0; dec0 = 0; vsc0 = 0; seen0 = 1'b1;
    end
    cyc0++;
    if (de0) dec0++;
    if (vs0) vsc0++;

    if (!rst3_n) seen3 = 1'b0;
    else begin
      if (fs3) begin
        if (seen3) begin
          chk("frame_period3", cyc3, FR);
          chk("de_per_frame3", dec3, HD * VD);
          chk("vsync_per_frame3", vsc3, VS * HT);
          frames3++;
        end
        cyc3 = 0; dec3 = 0; vsc3 = 0; seen3 = 1'b1;
      end
      cyc3++;
      if (de3) dec3++;
      if (!vs3) vsc3++;
    end
  end

  initial begin
    bit found;
    repeat (10) @(negedge pclk);
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    fork
      begin
        found = 1'b0;
        for (int i = 0; i < 2 * FR; i++) begin
          @(negedge pclk);
          if (cv1 == VA + 2 && ch1 == HA + 5) begin
            found = 1'b1;
            break;
          end
        end
        chk("u3_reset_point_reached", found, 1);
        if (found) begin
          #2 rst3_n = 1'b0;
          #1;
          chk("midreset_de3", de3, 0);
          chk("midreset_rgb3", rgb3, 0);
          chk("midreset_hsync3", hs3, 1);
          chk("midreset_vsync3", vs3, 1);
          chk("midreset_fs3", fs3, 0);
          chk("midreset_req3", req3, 0);
          repeat (3) @(negedge pclk);
          rst3_n = 1'b1;
        end
      end
      begin
        repeat (2 * FR + 2) @(negedge pclk);
        pat_en = 1'b1;
        repeat (FR + 40) @(negedge pclk);
        pat_en = 1'b0;
        repeat (FR / 2) @(negedge pclk);
      end
    join
    chk("frames_checked0", frames0 >= 2, 1);
    chk("frames_checked3", frames3 >= 1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_driver.md
# video_timing_driver

Generates the pixel-clock raster timing (hsync, vsync, data enable) for the DVI output path, and fetches RGB888 pixel data from the game drawing logic through a coordinate request interface. It compensates for a fixed upstream drawing latency so that `video_rgb` is cycle-aligned with `video_de`. Its outputs connect directly to the `video_din`, `video_hsync`, `video_vsync` and `video_de` inputs of the DVI transmitter. An internal 8-bar colour pattern is provided for bring-up.

## Interface
Parameters:
- `H_SYNC`, default 40: hsync width, pixels.
- `H_BACK`, default 220: horizontal back porch.
- `H_DISP`, default 1280: active pixels per line.
- `H_FRONT`, default 110: horizontal front porch. `H_TOTAL` = sum of the four = 1650.
- `V_SYNC`, default 5: vsync width, lines.
- `V_BACK`, default 20: vertical back porch.
- `V_DISP`, default 720: active lines.
- `V_FRONT`, default 5: vertical front porch. `V_TOTAL` = 750.
- `SYNC_POL`, default 1: 1 means sync pulses are active-high; 0 means active-low.
- `PIX_LATENCY`, default 2: number of cycles from `pixel_req` to valid `pixel_data`. Legal range is 1..(H_SYNC+H_BACK).

Ports:
- `pclk` in 1: pixel clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `pattern_en` in 1: 1 selects the internal colour bars instead of `pixel_data`.
- `pixel_req` out 1: a pixel is requested at (`pixel_xpos`, `pixel_ypos`).
- `pixel_xpos` out 12: active-area column, 0..H_DISP-1. It is 0 when `pixel_req` is low.
- `pixel_ypos` out 12: active-area row, 0..V_DISP-1. It is 0 when `pixel_req` is low.
- `pixel_data` in 24: RGB888 as {R,G,B}. It is valid exactly PIX_LATENCY cycles after the corresponding request.
- `video_hsync` out 1, `video_vsync` out 1, `video_de` out 1: registered timing outputs.
- `video_rgb` out 24: registered pixel value. It is 0 whenever `video_de` is 0.
- `frame_start` out 1: one-cycle pulse at the first cycle of each frame.

## Operation
- The block keeps two counters:
  - `h_cnt` runs 0..H_TOTAL-1 and wraps to 0.
  - `v_cnt` increments when `h_cnt` wraps. It runs 0..V_TOTAL-1 and wraps to 0.
  - Counter width is 12 bits.
- Line layout by `h_cnt`:
  - sync: [0, H_SYNC-1]
  - back porch: [H_SYNC, HA-1], where HA = H_SYNC+H_BACK = 260
  - active: [HA, HA+H_DISP-1] = [260, 1539]
  - front porch: the remainder.
- Frame layout by `v_cnt`: the same structure, with VA = V_SYNC+V_BACK = 25 and active lines [25, 744].
- Raw enable: `de_raw` is true when both `h_cnt` and `v_cnt` are inside their active windows.
- Request window: `pixel_req` is a combinational decode of the counter registers (no extra flop). It is high when `v_cnt` is active and `h_cnt` is in [HA-PIX_LATENCY, HA+H_DISP-1-PIX_LATENCY].
  - `pixel_xpos` = `h_cnt` - (HA - PIX_LATENCY).
  - `pixel_ypos` = `v_cnt` - VA.
- Output register stage, updated every `pclk` edge:
  - `video_hsync` = (`h_cnt` < H_SYNC) XNOR `SYNC_POL`-inverted, i.e. the active level during sync.
  - `video_vsync` is derived the same way from `v_cnt`.
  - `video_de` = `de_raw`.
  - `video_rgb` = `de_raw` ? (`pattern_en` ? bar : `pixel_data`) : 0.
  - `frame_start` = (`h_cnt`==0 && `v_cnt`==0).
- Colour bars: bar index = (`h_cnt`-HA)/(H_DISP/8). Indices 0..7 map to white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- `pattern_en` is sampled per pixel, so switching mid-frame takes effect on the next registered pixel.

## Timing
- Reset asserted (asynchronous) forces:
  - counters to 0
  - `video_de`=0, `video_rgb`=0, `frame_start`=0
  - `video_hsync`/`video_vsync` to their inactive level (0 when `SYNC_POL`=1, 1 when 0)
  - `pixel_req`=0 and positions 0, because the v-window is inactive.
- Reset is released synchronously to `pclk` by the system reset synchroniser. The first edge after release registers the state of `h_cnt`=0/`v_cnt`=0:
  - `frame_start`=1 for that cycle.
  - The sync outputs go active.
- Output latency is 1 cycle from the counter state. `video_de` is high while `h_cnt` is in [HA+1, HA+H_DISP], which is 1280 cycles per active line.
- Alignment: the request issued at `h_cnt` = HA-PIX_LATENCY+k delivers its data at `h_cnt` = HA+k. That data appears on `video_rgb` at `h_cnt` = HA+k+1, together with the k-th `video_de` cycle.
- The `pixel_xpos` sequence per line is 0..1279 and strictly consecutive. There are 720 request lines per frame.
- Wrap: `h_cnt` 1649→0 and `v_cnt` 749→0 happen on the same edge. `frame_start` follows on the next edge. There is exactly one `frame_start` per 1650×750 = 1,237,500 cycles.
- Reset asserted mid-frame immediately returns every output to its reset value, with no partial line completion. Timing restarts from `h_cnt`=0/`v_cnt`=0 after release.
- `pixel_data` is ignored outside the alignment window. `pattern_en` has no effect on sync or enable timing.

## Test plan
- Reset values: hold `reset_n`=0 for 10 cycles, then release. Required: all outputs at reset value while held; `frame_start`=1 on the first cycle after release; `video_hsync` high for exactly 40 cycles.
- Line and frame counts: run 2 frames with defaults. Required per frame:
  - 720 lines with exactly 1280 `video_de` cycles each
  - hsync period 1650
  - vsync high for 5×1650 = 8250 cycles
  - `frame_start` spacing 1,237,500.
- Latency alignment: PIX_LATENCY=2. The bench model returns `pixel_data` = {`xpos`[11:0], `ypos`[11:0]} two cycles after each `pixel_req`. Required: on every `video_de` cycle, `video_rgb` equals the expected {x,y}. The first pixel of row 0 is 000000; the last pixel of row 719 is {12'd1279, 12'd719}.
- Latency edge: repeat the alignment check with PIX_LATENCY=1 and PIX_LATENCY=260. Required: the same {x,y} check passes; for 260, `pixel_req` rises at `h_cnt`=0 of each active line.
- Pattern mode: `pattern_en`=1. Required:
  - active columns 0..159 = FFFFFF
  - columns 160..319 = FFFF00
  - columns 1120..1279 = 000000
  - `video_rgb`=0 during blanking.
- Mid-frame reset with `SYNC_POL`=0: pulse `reset_n` low at line 300, column 500. Required: outputs are immediately de=0, rgb=0, hsync=vsync=1; after release, `frame_start` fires and the full frame count matches the line and frame count check.
